instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of `cpu`, driving its 12-bit `instruction_bus`. It walks an 8-bit program counter over a req/ack instruction memory and buffers returned words in a small prefetch FIFO. The `cpu` consumes words through a valid/ready pair. A redirect input (jump/branch) flushes the buffer and restarts fetch at a new address.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/ifetch_fifo.sv | 75 +++++++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared constants and types for the instruction fetch stage.
//   ADDR_W        : program counter / instruction memory address width
//   INSTR_W       : instruction word width
//   NOP           : word shown to the cpu when the prefetch buffer is empty
//                   and IFETCH_NOP_FILL_EN is defined
//   fetch_state_t : fetch FSM states
package ifetch_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 12;
   localparam logic [INSTR_W-1:0] NOP = 12'h000;

   // S_IDLE : no request outstanding
   // S_WAIT : request outstanding, returned word will be kept
   // S_DROP : request outstanding, returned word is stale and discarded
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo
// Prefetch buffer between the instruction memory and the cpu.
// DEPTH x INSTR_W register array with head/tail pointers and an occupancy
// count. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear; wins over push and pop
//   push        : write push_data at the tail
//   push_data   : word to write
//   pop         : advance the head; ignored when empty
//   head_data   : word at the head (meaningful only when count != 0)
//   count       : number of stored words, 0..DEPTH
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [INSTR_W-1:0]           push_data,
   input  logic                         pop,
   output logic [INSTR_W-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic               pop_ok;
   logic               push_ok;

   // A pop on an empty buffer is dropped. A push is only taken while a slot
   // is free, counting the slot freed by a simultaneous pop.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != FULL_CNT) || pop_ok);

   assign head_data = mem[head];

   // Storage, pointers and count. Flush only rewinds the pointers and count;
   // the stale words left in the array are never visible because count is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= NOP;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            mem[tail] <= push_data;
            tail      <= tail + PTR_W'(1);
         end
         if (pop_ok) begin
            head <= head + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch stage feeding the cpu. Walks an 8-bit program counter
// over a req/ack instruction memory (one request outstanding at most) and
// buffers returned words in a DEPTH-entry prefetch FIFO. A redirect pulse
// flushes the buffer and restarts fetch at redirect_addr; a request already
// in flight at that moment is completed and its word thrown away.
// Configuration macro: IFETCH_NOP_FILL_EN
//   defined   : instruction_bus shows NOP (12'h000) whenever the buffer is empty
//   undefined : instruction_bus keeps the last head word when empty
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_req        : fetch request, held until imem_ack
//   imem_addr       : fetch address, stable while imem_req is high
//   imem_ack        : memory accepts the request, imem_data valid same cycle
//   imem_data       : returned instruction word
//   instruction_bus : FIFO head word to the cpu
//   instr_valid     : instruction_bus holds a real instruction
//   instr_ready     : cpu consumes the head when instr_valid is high
//   redirect        : one-cycle pulse, flush and refetch
//   redirect_addr   : new program counter, sampled with redirect
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instruction_bus,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_addr
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_state_t       state;
   fetch_state_t       next_state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  next_pc;
   logic               push;
   logic               pop_ok;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_after;
   logic [INSTR_W-1:0] head_data;

   assign instr_valid = (count != '0);

   // A redirect flushes the buffer, so a pop in the same cycle has no effect.
   assign pop_ok = instr_valid && instr_ready && !redirect;

   ifetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (push),
      .push_data (imem_data),
      .pop       (pop_ok),
      .head_data (head_data),
      .count     (count)
   );

   // Next-state logic. A new request is only started while a slot is free,
   // and after a push we keep requesting only if the buffer still has room
   // once this cycle's pop is accounted for; this is what guarantees the
   // FIFO never sees a push while full. A redirect always lands in pc, and
   // an outstanding request becomes a stale one (S_DROP) unless it is acked
   // in the same cycle.
   always_comb begin
      next_state  = state;
      next_pc     = pc;
      push        = 1'b0;
      count_after = pop_ok ? count : count + CNT_W'(1);
      case (state)
         S_IDLE: begin
            if (!redirect && (count < FULL_CNT)) begin
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               next_state = imem_ack ? S_IDLE : S_DROP;
            end else if (imem_ack) begin
               push       = 1'b1;
               next_pc    = pc + ADDR_W'(1);
               next_state = (count_after < FULL_CNT) ? S_WAIT : S_IDLE;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
      if (redirect) begin
         next_pc = redirect_addr;
      end
   end

   // State, pc and the registered memory interface. imem_addr is only
   // reloaded when entering or staying in S_WAIT, so during S_DROP it keeps
   // the address of the stale request until that request is acked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= '0;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         state    <= next_state;
         pc       <= next_pc;
         imem_req <= (next_state != S_IDLE);
         if (next_state == S_WAIT) begin
            imem_addr <= next_pc;
         end
      end
   end

`ifdef IFETCH_NOP_FILL_EN
   assign instruction_bus = instr_valid ? head_data : NOP;
`else
   logic [INSTR_W-1:0] last_head;

   // Remember the head word while the buffer is non-empty so the bus keeps
   // showing the last word once the buffer drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_head <= NOP;
      end else if (instr_valid) begin
         last_head <= head_data;
      end
   end

   assign instruction_bus = instr_valid ? head_data : last_head;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// tb_instr_fetch
// Self-checking bench for instr_fetch. Stimulus pushes expected fetch
// addresses, expected consumed words and point checks into queues; a
// negedge monitor pops and compares them.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [11:0] imem_data;
   logic [11:0] instruction_bus;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_addr;

   int checks = 0;
   int errors = 0;

   logic [7:0]  addrQ[$];
   logic [11:0] expQ[$];
   string       chkName[$];
   logic [31:0] chkAct[$];
   logic [31:0] chkExp[$];

   // Instruction memory contents: low nibble of the address folded into the
   // top nibble, so every address in the test gives a distinct word.
   function automatic logic [11:0] memWord(input logic [7:0] a);
      return {a[3:0] ^ 4'hC, a};
   endfunction

   assign imem_data = memWord(imem_addr);

   instr_fetch #(
      .DEPTH(4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_data       (imem_data),
      .instruction_bus (instruction_bus),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .redirect        (redirect),
      .redirect_addr   (redirect_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs starting now, return 1ns after the next edge.
   task automatic applyStimulus(input logic ackIn, input logic readyIn,
                                input logic redirIn, input logic [7:0] addrIn);
      imem_ack      = ackIn;
      instr_ready   = readyIn;
      redirect      = redirIn;
      redirect_addr = addrIn;
      @(posedge clk);
      #1;
   endtask

   // Queue a point check for the monitor.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      chkName.push_back(name);
      chkAct.push_back(act);
      chkExp.push_back(exp);
   endtask

   // Monitor: inputs only change 1ns after a posedge, so values seen at the
   // negedge are exactly what the DUT acts on at the following posedge.
   always @(negedge clk) begin : monitor
      logic [7:0]  expAddr;
      logic [11:0] expWord;
      if (imem_req && imem_ack) begin
         checks++;
         if (addrQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_request actual addr=%02h required none", imem_addr);
         end else begin
            expAddr = addrQ.pop_front();
            if (imem_addr !== expAddr) begin
               errors++;
               $display("[TB] FAIL fetch_addr actual=%02h required=%02h", imem_addr, expAddr);
            end
         end
      end
      if (instr_valid && instr_ready && !redirect) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_consume actual word=%03h required none", instruction_bus);
         end else begin
            expWord = expQ.pop_front();
            if (instruction_bus !== expWord) begin
               errors++;
               $display("[TB] FAIL consumed_word actual=%03h required=%03h", instruction_bus, expWord);
            end
         end
      end
      while (chkName.size() > 0) begin
         string       n;
         logic [31:0] a;
         logic [31:0] e;
         n = chkName.pop_front();
         a = chkAct.pop_front();
         e = chkExp.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", n, a, e);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      imem_ack      = 1'b0;
      instr_ready   = 1'b0;
      redirect      = 1'b0;
      redirect_addr = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req",   32'(imem_req),        32'h0);
      checkOutput("reset_addr",  32'(imem_addr),       32'h00);
      checkOutput("reset_valid", 32'(instr_valid),     32'h0);
      checkOutput("reset_bus",   32'(instruction_bus), 32'h000);
      rst_n = 1'b1;

      // Streaming with ack tied high and ready high.
      for (int i = 0; i <= 4; i++) addrQ.push_back(8'(i));
      for (int i = 0; i <= 2; i++) expQ.push_back(memWord(8'(i)));
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      $display("[TB] streaming from reset");
      checkOutput("first_req",      32'(imem_req),    32'h1);
      checkOutput("first_addr",     32'(imem_addr),   32'h00);
      checkOutput("first_no_valid", 32'(instr_valid), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("ack_to_valid", 32'(instr_valid),     32'h1);
      checkOutput("first_word",   32'(instruction_bus), 32'hC00);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      // Redirect back to 00 coincident with ack and pop: both are dropped.
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
      checkOutput("redir0_valid", 32'(instr_valid), 32'h0);
      checkOutput("redir0_req",   32'(imem_req),    32'h0);

      // Back-pressure: buffer fills to DEPTH and requests stop.
      for (int i = 0; i <= 3; i++) addrQ.push_back(8'(i));
      $display("[TB] back-pressure fill");
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("full_req",   32'(imem_req),        32'h0);
      checkOutput("full_valid", 32'(instr_valid),     32'h1);
      checkOutput("full_head",  32'(instruction_bus), 32'hC00);
      checkOutput("full_count", 32'(dut.count),       32'h4);

      // Drain in order and resume fetching at 04.
      for (int i = 0; i <= 3; i++) expQ.push_back(memWord(8'(i)));
      addrQ.push_back(8'h04);
      addrQ.push_back(8'h05);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("resume_req",  32'(imem_req),  32'h1);
      checkOutput("resume_addr", 32'(imem_addr), 32'h04);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

      // Redirect to 40 while waiting, stale ack three cycles later.
      $display("[TB] redirect with delayed ack");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
      checkOutput("drop_valid", 32'(instr_valid), 32'h0);
      checkOutput("drop_req",   32'(imem_req),    32'h1);
      checkOutput("drop_addr",  32'(imem_addr),   32'h06);
      addrQ.push_back(8'h06);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("drop_hold_addr", 32'(imem_addr), 32'h06);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("stale_req",   32'(imem_req),    32'h0);
      checkOutput("stale_valid", 32'(instr_valid), 32'h0);
      addrQ.push_back(8'h40);
      addrQ.push_back(8'h41);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("refetch_req",  32'(imem_req),  32'h1);
      checkOutput("refetch_addr", 32'(imem_addr), 32'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("refetch_valid", 32'(instr_valid),     32'h1);
      checkOutput("refetch_word",  32'(instruction_bus), 32'hC40);

      // Redirect to FE coincident with ack and pop.
      $display("[TB] redirect with ack and pop, wrap");
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE);
      checkOutput("coinc_valid", 32'(instr_valid), 32'h0);
      checkOutput("coinc_req",   32'(imem_req),    32'h0);
      checkOutput("coinc_count", 32'(dut.count),   32'h0);
      addrQ.push_back(8'hFE);
      addrQ.push_back(8'hFF);
      addrQ.push_back(8'h00);
      addrQ.push_back(8'h01);
      addrQ.push_back(8'h02);
      expQ.push_back(12'h2FE);
      expQ.push_back(12'h3FF);
      expQ.push_back(12'hC00);
      expQ.push_back(12'hD01);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("wrap_first_addr", 32'(imem_addr), 32'hFE);
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

      // Asynchronous reset in the middle of a request.
      $display("[TB] mid-request reset");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_req",   32'(imem_req),        32'h0);
      checkOutput("async_addr",  32'(imem_addr),       32'h00);
      checkOutput("async_valid", 32'(instr_valid),     32'h0);
      checkOutput("async_bus",   32'(instruction_bus), 32'h000);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("held_reset_req",   32'(imem_req),    32'h0);
      checkOutput("held_reset_valid", 32'(instr_valid), 32'h0);
      rst_n = 1'b1;
      addrQ.push_back(8'h00);
      addrQ.push_back(8'h01);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("post_reset_valid", 32'(instr_valid),     32'h1);
      checkOutput("post_reset_word",  32'(instruction_bus), 32'hC00);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

      checkOutput("leftover_words", 32'(expQ.size()),  32'h0);
      checkOutput("leftover_addrs", 32'(addrQ.size()), 32'h0);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
